// File: rtl/decode_issue_unit_pkg.sv
// Shared decode constants for the decode/issue slice: RV32I opcodes, instruction
// field positions, operand-source encoding and small helpers.
package decode_issue_unit_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BR     = 7'b1100011;
    localparam logic [6:0] OPCODE_L      = 7'b0000011;
    localparam logic [6:0] OPCODE_S      = 7'b0100011;
    localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;

    // Low bit of each instruction field (all register fields are 5 bits wide)
    localparam int RD_LO      = 7;
    localparam int FUNCT3_LO  = 12;
    localparam int RS1_LO     = 15;
    localparam int RS2_LO     = 20;
    localparam int FUNCT7_BIT = 30;

    // Where a resolved operand value comes from
    localparam logic [2:0] SRC_MASKED = 3'd0;
    localparam logic [2:0] SRC_REG    = 3'd1;
    localparam logic [2:0] SRC_ROB    = 3'd2;
    localparam logic [2:0] SRC_CDB    = 3'd3;
    localparam logic [2:0] SRC_TAG    = 3'd4;

    // A ROB id is a position plus the "renamed/pending" flag in the MSB
    function automatic int rob_id_width(input int pos_w);
        return pos_w + 1;
    endfunction

    // Operand priority: masked, then a clean register value, then ROB, then CDB.
    // A bypass hit forces the renamed path even if the register file looks clean.
    function automatic logic [2:0] resolve_src(input logic masked, input logic byp_hit,
                                               input logic reg_pending, input logic rob_ready,
                                               input logic cdb_hit);
        logic [2:0] src;
        if (masked)                        src = SRC_MASKED;
        else if (!byp_hit && !reg_pending) src = SRC_REG;
        else if (rob_ready)                src = SRC_ROB;
        else if (cdb_hit)                  src = SRC_CDB;
        else                               src = SRC_TAG;
        return src;
    endfunction

endpackage

// File: rtl/decode_issue_unit_inst_queue.sv
// Instruction FIFO between fetch and decode. Pointers carry one extra wrap bit so
// full and empty are distinguishable; flush empties it in one cycle.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 65
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_en && !i_flush && i_push && !o_full;
    assign w_do_pop  = i_en && !i_flush && i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update: reset/flush empties the queue, otherwise advance on push/pop
    always_ff @(posedge i_clk) begin
        if (i_rst || (i_en && i_flush)) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Entry storage; only slots between the pointers are ever read as valid
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: queues fetched RV32I instructions, decodes the head entry,
// resolves operands (bypass > regfile > ROB > CDB > tag) and issues one
// instruction per cycle through registered outputs to the RS or LSB.
module decode_issue_unit
    import decode_issue_unit_pkg::*;
#(
    parameter int IQ_DEPTH  = 8,
    parameter int ROB_POS_W = 4,
    parameter int NUM_CDB   = 2,
    parameter int XLEN      = 32,
    localparam int ROB_ID_W = rob_id_width(ROB_POS_W)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rdy,
    input  logic                      i_rollback,
    input  logic [ROB_POS_W-1:0]      i_rob_tail_in,
    input  logic                      i_inst_valid,
    output logic                      o_inst_ready,
    input  logic [31:0]               i_inst,
    input  logic [31:0]               i_inst_pc,
    input  logic                      i_inst_pred_jump,
    output logic [4:0]                o_reg_rs1,
    output logic [4:0]                o_reg_rs2,
    input  logic [XLEN-1:0]           i_reg_rs1_val,
    input  logic [XLEN-1:0]           i_reg_rs2_val,
    input  logic [ROB_ID_W-1:0]       i_reg_rs1_rob_id,
    input  logic [ROB_ID_W-1:0]       i_reg_rs2_rob_id,
    output logic [ROB_POS_W-1:0]      o_rob_rs1_pos,
    output logic [ROB_POS_W-1:0]      o_rob_rs2_pos,
    input  logic                      i_rob_rs1_ready,
    input  logic [XLEN-1:0]           i_rob_rs1_val,
    input  logic                      i_rob_rs2_ready,
    input  logic [XLEN-1:0]           i_rob_rs2_val,
    input  logic [NUM_CDB-1:0]        i_cdb_valid,
    input  logic [NUM_CDB*ROB_POS_W-1:0] i_cdb_rob_pos,
    input  logic [NUM_CDB*XLEN-1:0]   i_cdb_val,
    input  logic                      i_rob_full,
    input  logic                      i_rs_full,
    input  logic                      i_lsb_full,
    output logic                      o_issue,
    output logic                      o_rs_en,
    output logic                      o_lsb_en,
    output logic                      o_is_store,
    output logic                      o_is_ready,
    output logic                      o_pred_jump,
    output logic [ROB_POS_W-1:0]      o_rob_pos,
    output logic [6:0]                o_opcode,
    output logic [2:0]                o_funct3,
    output logic                      o_funct7,
    output logic [XLEN-1:0]           o_rs1_val,
    output logic [XLEN-1:0]           o_rs2_val,
    output logic [XLEN-1:0]           o_imm,
    output logic [XLEN-1:0]           o_pc,
    output logic [ROB_ID_W-1:0]       o_rs1_rob_id,
    output logic [ROB_ID_W-1:0]       o_rs2_rob_id,
    output logic [4:0]                o_rd,
    output logic                      o_illegal
);
    localparam logic [ROB_POS_W-1:0] POS_ONE = {{(ROB_POS_W-1){1'b0}}, 1'b1};

    // ---------------- queue ----------------
    logic [64:0] w_head;
    logic        w_empty, w_full, w_pop;
    logic [31:0] w_inst, w_pc;
    logic        w_pred;

    inst_queue #(.DEPTH(IQ_DEPTH), .W(65)) u_iq (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_rdy), .i_flush(i_rollback),
        .i_push(i_inst_valid), .i_data({i_inst_pred_jump, i_inst_pc, i_inst}),
        .i_pop(w_pop), .o_data(w_head), .o_empty(w_empty), .o_full(w_full)
    );

    assign o_inst_ready = !w_full;
    assign {w_pred, w_pc, w_inst} = w_head;

    // ---------------- decode ----------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd_eff;
    logic        w_legal, w_rs_en, w_lsb_en, w_is_store, w_is_ready;
    logic        w_use_rs1, w_use_rs2, w_has_rd;
    logic [31:0] w_imm;

    assign w_opcode = w_inst[6:0];
    assign w_rd_eff = w_has_rd ? w_inst[RD_LO +: 5] : 5'd0;

    // Per-opcode unit select, operand usage and immediate format
    always_comb begin
        w_legal = 1'b0; w_rs_en = 1'b0; w_lsb_en = 1'b0; w_is_store = 1'b0; w_is_ready = 1'b0;
        w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_has_rd = 1'b0; w_imm = 32'd0;
        case (w_opcode)
            OPCODE_S: begin
                w_legal = 1'b1; w_lsb_en = 1'b1; w_is_store = 1'b1; w_is_ready = 1'b1;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            OPCODE_L: begin
                w_legal = 1'b1; w_lsb_en = 1'b1; w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OPCODE_ARITHI, OPCODE_JALR: begin
                w_legal = 1'b1; w_rs_en = 1'b1; w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OPCODE_ARITH: begin
                w_legal = 1'b1; w_rs_en = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_has_rd = 1'b1;
            end
            OPCODE_BR: begin
                w_legal = 1'b1; w_rs_en = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
            end
            OPCODE_JAL: begin
                w_legal = 1'b1; w_rs_en = 1'b1; w_has_rd = 1'b1;
                w_imm = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                w_legal = 1'b1; w_rs_en = 1'b1; w_has_rd = 1'b1;
                w_imm = {w_inst[31:12], 12'd0};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // ---------------- operand resolution ----------------
    logic [4:0]           r_bypass_rd;
    logic [ROB_POS_W-1:0] r_bypass_pos;
    logic                 r_bypass_valid;

    for (genvar op = 0; op < 2; op++) begin : g_opnd
        logic [4:0]           w_rs;
        logic                 w_use, w_byp_hit, w_rob_ready;
        logic [ROB_ID_W-1:0]  w_reg_tag;
        logic [XLEN-1:0]      w_reg_val, w_rob_val, w_cdb_sel, w_val;
        logic [ROB_POS_W-1:0] w_q_pos;
        logic [NUM_CDB-1:0]   w_cdb_hit;
        logic [2:0]           w_src;
        logic [ROB_ID_W-1:0]  w_tag;

        assign w_use       = (op == 0) ? w_use_rs1 : w_use_rs2;
        assign w_rs        = !w_use ? 5'd0 : ((op == 0) ? w_inst[RS1_LO +: 5] : w_inst[RS2_LO +: 5]);
        assign w_reg_tag   = (op == 0) ? i_reg_rs1_rob_id : i_reg_rs2_rob_id;
        assign w_reg_val   = (op == 0) ? i_reg_rs1_val : i_reg_rs2_val;
        assign w_rob_ready = (op == 0) ? i_rob_rs1_ready : i_rob_rs2_ready;
        assign w_rob_val   = (op == 0) ? i_rob_rs1_val : i_rob_rs2_val;
        // The previous issue's rename is not yet visible in the register file
        assign w_byp_hit   = r_bypass_valid && (w_rs == r_bypass_rd) && (w_rs != 5'd0);
        assign w_q_pos     = w_byp_hit ? r_bypass_pos : w_reg_tag[ROB_POS_W-1:0];

        for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
            assign w_cdb_hit[c] = i_cdb_valid[c] && (i_cdb_rob_pos[c*ROB_POS_W +: ROB_POS_W] == w_q_pos);
        end

        // Lowest-index matching broadcast channel wins
        always_comb begin
            w_cdb_sel = {XLEN{1'b0}};
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (w_cdb_hit[c]) w_cdb_sel = i_cdb_val[c*XLEN +: XLEN];
                else              w_cdb_sel = w_cdb_sel;
            end
        end

        assign w_src = resolve_src(!w_use, w_byp_hit, w_reg_tag[ROB_POS_W], w_rob_ready, |w_cdb_hit);

        // Value/tag pair for the chosen source; a tag of 0 means the value is final
        always_comb begin
            w_val = {XLEN{1'b0}};
            w_tag = {ROB_ID_W{1'b0}};
            case (w_src)
                SRC_REG: w_val = w_reg_val;
                SRC_ROB: w_val = w_rob_val;
                SRC_CDB: w_val = w_cdb_sel;
                SRC_TAG: w_tag = {1'b1, w_q_pos};
                default: w_val = {XLEN{1'b0}};
            endcase
        end
    end

    assign o_reg_rs1     = g_opnd[0].w_rs;
    assign o_reg_rs2     = g_opnd[1].w_rs;
    assign o_rob_rs1_pos = g_opnd[0].w_q_pos;
    assign o_rob_rs2_pos = g_opnd[1].w_q_pos;

    // ---------------- issue control ----------------
    logic w_head_ok, w_fire, w_drop;
    logic r_issue, r_illegal;
    logic [ROB_POS_W-1:0] r_alloc_ptr;

    assign w_head_ok = i_rdy && !i_rollback && !w_empty;
    assign w_fire    = w_head_ok && w_legal && !i_rob_full && !(w_rs_en ? i_rs_full : i_lsb_full);
    assign w_drop    = w_head_ok && !w_legal;
    assign w_pop     = w_fire || w_drop;

    // Pulses are held while stalled and masked so a stalled consumer never sees them twice
    assign o_issue   = r_issue && i_rdy;
    assign o_illegal = r_illegal && i_rdy;

    // Issue/illegal pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_issue   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (i_rdy) begin
            r_issue   <= w_fire;
            r_illegal <= w_drop;
        end
    end

    // Issue payload: captured on issue, forced to zero on any other enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_rst || (i_rdy && !w_fire)) begin
            o_rs_en <= 1'b0; o_lsb_en <= 1'b0; o_is_store <= 1'b0; o_is_ready <= 1'b0;
            o_pred_jump <= 1'b0; o_rob_pos <= {ROB_POS_W{1'b0}}; o_opcode <= 7'd0;
            o_funct3 <= 3'd0; o_funct7 <= 1'b0; o_rs1_val <= {XLEN{1'b0}}; o_rs2_val <= {XLEN{1'b0}};
            o_imm <= {XLEN{1'b0}}; o_pc <= {XLEN{1'b0}}; o_rs1_rob_id <= {ROB_ID_W{1'b0}};
            o_rs2_rob_id <= {ROB_ID_W{1'b0}}; o_rd <= 5'd0;
        end else if (w_fire) begin
            o_rs_en <= w_rs_en; o_lsb_en <= w_lsb_en; o_is_store <= w_is_store; o_is_ready <= w_is_ready;
            o_pred_jump <= w_pred; o_rob_pos <= r_alloc_ptr; o_opcode <= w_opcode;
            o_funct3 <= w_inst[FUNCT3_LO +: 3]; o_funct7 <= w_inst[FUNCT7_BIT];
            o_rs1_val <= g_opnd[0].w_val; o_rs2_val <= g_opnd[1].w_val;
            o_imm <= XLEN'($signed(w_imm)); o_pc <= XLEN'(w_pc);
            o_rs1_rob_id <= g_opnd[0].w_tag; o_rs2_rob_id <= g_opnd[1].w_tag; o_rd <= w_rd_eff;
        end
    end

    // ROB allocation pointer and last-issue rename bypass
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alloc_ptr    <= {ROB_POS_W{1'b0}};
            r_bypass_rd    <= 5'd0;
            r_bypass_pos   <= {ROB_POS_W{1'b0}};
            r_bypass_valid <= 1'b0;
        end else if (i_rdy) begin
            if (i_rollback) begin
                r_alloc_ptr    <= i_rob_tail_in;
                r_bypass_valid <= 1'b0;
            end else if (w_fire) begin
                r_alloc_ptr    <= r_alloc_ptr + POS_ONE;
                r_bypass_rd    <= w_rd_eff;
                r_bypass_pos   <= r_alloc_ptr;
                r_bypass_valid <= (w_rd_eff != 5'd0);
            end else if (!w_drop) begin
                r_bypass_valid <= 1'b0;
            end
        end
    end

endmodule
